// File: rtl/wb_arbiter.sv
// Two-port round-robin arbiter sharing one Wishbone master between the
// instruction-fetch port (0) and the load/store port (1); one transaction in flight.
module wb_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    p0_start_rd_i,
  input  logic                    p0_start_wr_i,
  input  logic [DATA_WIDTH/8-1:0] p0_sel_i,
  input  logic [DATA_WIDTH-1:0]   p0_data_i,
  input  logic [ADDR_WIDTH-1:0]   p0_addr_i,
  output logic                    p0_done_o,
  output logic [DATA_WIDTH-1:0]   p0_data_o,
  input  logic                    p1_start_rd_i,
  input  logic                    p1_start_wr_i,
  input  logic [DATA_WIDTH/8-1:0] p1_sel_i,
  input  logic [DATA_WIDTH-1:0]   p1_data_i,
  input  logic [ADDR_WIDTH-1:0]   p1_addr_i,
  output logic                    p1_done_o,
  output logic [DATA_WIDTH-1:0]   p1_data_o,
  output logic                    m_start_rd_o,
  output logic                    m_start_wr_o,
  output logic [DATA_WIDTH/8-1:0] m_sel_o,
  output logic [DATA_WIDTH-1:0]   m_data_o,
  output logic [ADDR_WIDTH-1:0]   m_addr_o,
  input  logic                    m_done_i,
  input  logic [DATA_WIDTH-1:0]   m_data_i,
  output logic [1:0]              grant_o,
  output logic                    busy_o
);

  localparam int SEL_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RELEASE} state_t;

  // Handshake: requests are level-held from assertion until the port sees its
  // one-cycle done pulse, and must be dropped by the edge that ends that cycle.
  state_t                state;
  logic                  last_q;
  logic                  rd_q;

  logic                  p0_req;
  logic                  p1_req;
  logic                  pick1;
  logic                  win_rd;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [SEL_WIDTH-1:0]  win_sel;
  logic [DATA_WIDTH-1:0] win_data;

  assign p0_req = p0_start_rd_i | p0_start_wr_i;
  assign p1_req = p1_start_rd_i | p1_start_wr_i;
  // On a tie the port that did not win last time goes next.
  assign pick1  = p1_req & (~p0_req | ~last_q);

  always_comb begin
    win_rd   = p0_start_rd_i;
    win_addr = p0_addr_i;
    win_sel  = p0_sel_i;
    win_data = p0_data_i;
    if (pick1) begin
      win_rd   = p1_start_rd_i;
      win_addr = p1_addr_i;
      win_sel  = p1_sel_i;
      win_data = p1_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= IDLE;
      last_q       <= 1'b1;
      rd_q         <= 1'b0;
      p0_done_o    <= 1'b0;
      p0_data_o    <= '0;
      p1_done_o    <= 1'b0;
      p1_data_o    <= '0;
      m_start_rd_o <= 1'b0;
      m_start_wr_o <= 1'b0;
      m_sel_o      <= '0;
      m_data_o     <= '0;
      m_addr_o     <= '0;
      grant_o      <= 2'b00;
      busy_o       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (p0_req || p1_req) begin
            state        <= ISSUE;
            busy_o       <= 1'b1;
            grant_o      <= pick1 ? 2'b10 : 2'b01;
            last_q       <= pick1;
            rd_q         <= win_rd;
            m_start_rd_o <= win_rd;
            m_start_wr_o <= ~win_rd;
            m_addr_o     <= win_addr;
            m_sel_o      <= win_rd ? '0 : win_sel;
            m_data_o     <= win_rd ? '0 : win_data;
          end
        end
        ISSUE: begin
          m_start_rd_o <= 1'b0;
          m_start_wr_o <= 1'b0;
          state        <= WAIT;
        end
        WAIT: begin
          if (m_done_i) begin
            state <= RELEASE;
            if (grant_o[1]) begin
              p1_done_o <= 1'b1;
              p1_data_o <= rd_q ? m_data_i : '0;
            end else begin
              p0_done_o <= 1'b1;
              p0_data_o <= rd_q ? m_data_i : '0;
            end
          end
        end
        RELEASE: begin
          p0_done_o <= 1'b0;
          p0_data_o <= '0;
          p1_done_o <= 1'b0;
          p1_data_o <= '0;
          grant_o   <= 2'b00;
          busy_o    <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: requester drivers, a master model that checks start
// pulses against an expected queue, and a done monitor with its own queue.
module tb_wb_arbiter;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int SW    = DW / 8;
  localparam int OUT_W = 2 * (1 + DW) + 2 + SW + DW + AW + 2 + 1;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          p0_start_rd_i, p0_start_wr_i;
  logic [SW-1:0] p0_sel_i;
  logic [DW-1:0] p0_data_i;
  logic [AW-1:0] p0_addr_i;
  logic          p0_done_o;
  logic [DW-1:0] p0_data_o;
  logic          p1_start_rd_i, p1_start_wr_i;
  logic [SW-1:0] p1_sel_i;
  logic [DW-1:0] p1_data_i;
  logic [AW-1:0] p1_addr_i;
  logic          p1_done_o;
  logic [DW-1:0] p1_data_o;
  logic          m_start_rd_o, m_start_wr_o;
  logic [SW-1:0] m_sel_o;
  logic [DW-1:0] m_data_o;
  logic [AW-1:0] m_addr_o;
  logic          m_done_i;
  logic [DW-1:0] m_data_i;
  logic [1:0]    grant_o;
  logic          busy_o;

  wb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .p0_start_rd_i(p0_start_rd_i), .p0_start_wr_i(p0_start_wr_i), .p0_sel_i(p0_sel_i),
    .p0_data_i(p0_data_i), .p0_addr_i(p0_addr_i), .p0_done_o(p0_done_o), .p0_data_o(p0_data_o),
    .p1_start_rd_i(p1_start_rd_i), .p1_start_wr_i(p1_start_wr_i), .p1_sel_i(p1_sel_i),
    .p1_data_i(p1_data_i), .p1_addr_i(p1_addr_i), .p1_done_o(p1_done_o), .p1_data_o(p1_data_o),
    .m_start_rd_o(m_start_rd_o), .m_start_wr_o(m_start_wr_o), .m_sel_o(m_sel_o),
    .m_data_o(m_data_o), .m_addr_o(m_addr_o), .m_done_i(m_done_i), .m_data_i(m_data_i),
    .grant_o(grant_o), .busy_o(busy_o)
  );

  wire [OUT_W-1:0] all_out = {p0_done_o, p0_data_o, p1_done_o, p1_data_o, m_start_rd_o,
                              m_start_wr_o, m_sel_o, m_data_o, m_addr_o, grant_o, busy_o};

  typedef struct packed {
    logic          port;
    logic          rd;
    logic [AW-1:0] addr;
    logic [SW-1:0] sel;
    logic [DW-1:0] data;
  } txn_t;

  typedef struct packed {
    logic          port;
    logic [DW-1:0] data;
  } done_t;

  txn_t          exp_q[$];
  done_t         done_q[$];
  int            checks = 0;
  int            errors = 0;
  bit            master_auto = 1'b1;
  bit            stray_done = 1'b0;
  logic [DW-1:0] rdata_next = 32'h0BAD_F00D;

  // Clock / reset
  always #5 clk_i = ~clk_i;

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  // Master model: checks each start pulse against exp_q, then answers with done
  initial begin : master_model
    txn_t          e;
    done_t         d;
    logic [1:0]    exp_grant;
    m_done_i = 1'b0;
    m_data_i = '0;
    forever begin
      @(negedge clk_i);
      if (stray_done) begin
        m_done_i = 1'b1;
        m_data_i = 32'hFFFF_FFFF;
        @(negedge clk_i);
        m_done_i   = 1'b0;
        stray_done = 1'b0;
      end else if (m_start_rd_o || m_start_wr_o) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL start_unexpected: got rd=%0b wr=%0b addr=%h, required no start",
                   m_start_rd_o, m_start_wr_o, m_addr_o);
        end else begin
          e = exp_q.pop_front();
          exp_grant = e.port ? 2'b10 : 2'b01;
          checks++;
          if ({m_start_rd_o, m_start_wr_o} !== {e.rd, ~e.rd}) begin
            errors++;
            $display("FAIL start_kind: got rd/wr=%b, required %b", {m_start_rd_o, m_start_wr_o}, {e.rd, ~e.rd});
          end
          checks++;
          if (m_addr_o !== e.addr) begin
            errors++;
            $display("FAIL start_addr: got %h, required %h", m_addr_o, e.addr);
          end
          checks++;
          if (m_sel_o !== e.sel) begin
            errors++;
            $display("FAIL start_sel: got %b, required %b", m_sel_o, e.sel);
          end
          checks++;
          if (m_data_o !== e.data) begin
            errors++;
            $display("FAIL start_data: got %h, required %h", m_data_o, e.data);
          end
          checks++;
          if (grant_o !== exp_grant) begin
            errors++;
            $display("FAIL start_grant: got %b, required %b", grant_o, exp_grant);
          end
          if (master_auto) begin
            @(negedge clk_i);
            checks++;
            if ((m_start_rd_o | m_start_wr_o) !== 1'b0) begin
              errors++;
              $display("FAIL start_width: got start still high, required single-cycle pulse");
            end
            repeat ($urandom_range(0, 3)) @(negedge clk_i);
            m_data_i = rdata_next;
            m_done_i = 1'b1;
            d.port   = e.port;
            d.data   = e.rd ? rdata_next : '0;
            done_q.push_back(d);
            rdata_next = $urandom;
            @(negedge clk_i);
            m_done_i = 1'b0;
            m_data_i = $urandom;
            checks++;
            if ((e.port ? p1_done_o : p0_done_o) !== 1'b1) begin
              errors++;
              $display("FAIL done_latency: port %0d done=0 one cycle after m_done_i, required 1", e.port);
            end
          end
        end
      end
    end
  end

  // Done monitor: routes and data of every done pulse
  always @(negedge clk_i) begin : done_monitor
    done_t d;
    if (!rst_i) begin
      if (p0_done_o || p1_done_o) begin
        checks++;
        if (done_q.size() == 0) begin
          errors++;
          $display("FAIL done_unexpected: got p0_done=%0b p1_done=%0b, required none", p0_done_o, p1_done_o);
        end else begin
          d = done_q.pop_front();
          checks++;
          if ({p1_done_o, p0_done_o} !== {d.port, ~d.port}) begin
            errors++;
            $display("FAIL done_route: got p1/p0 done=%b, required %b", {p1_done_o, p0_done_o}, {d.port, ~d.port});
          end
          checks++;
          if ((d.port ? p1_data_o : p0_data_o) !== d.data || (d.port ? p0_data_o : p1_data_o) !== '0) begin
            errors++;
            $display("FAIL done_data: got p0=%h p1=%h, required port %0d data %h, other 0",
                     p0_data_o, p1_data_o, d.port, d.data);
          end
        end
      end else begin
        checks++;
        if (p0_data_o !== '0 || p1_data_o !== '0) begin
          errors++;
          $display("FAIL idle_data: got p0=%h p1=%h without done, required 0", p0_data_o, p1_data_o);
        end
      end
    end
  end

  // Driver tasks
  task automatic clear_inputs();
    p0_start_rd_i = 0; p0_start_wr_i = 0; p0_sel_i = '0; p0_data_i = '0; p0_addr_i = '0;
    p1_start_rd_i = 0; p1_start_wr_i = 0; p1_sel_i = '0; p1_data_i = '0; p1_addr_i = '0;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic run_req(input bit port, input bit rd, input bit wr, input logic [AW-1:0] addr,
                         input logic [SW-1:0] sel, input logic [DW-1:0] data);
    bit seen = 0;
    if (port) begin
      p1_addr_i = addr; p1_sel_i = sel; p1_data_i = data; p1_start_rd_i = rd; p1_start_wr_i = wr;
    end else begin
      p0_addr_i = addr; p0_sel_i = sel; p0_data_i = data; p0_start_rd_i = rd; p0_start_wr_i = wr;
    end
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_i);
      if ((port ? p1_done_o : p0_done_o) === 1'b1) begin
        seen = 1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL req_timeout: port %0d done not seen in 100 cycles, required done", port);
    end
    if (port) begin p1_start_rd_i = 0; p1_start_wr_i = 0; end
    else begin p0_start_rd_i = 0; p0_start_wr_i = 0; end
  endtask

  task automatic push_exp(input bit port, input bit rd, input logic [AW-1:0] addr,
                          input logic [SW-1:0] sel, input logic [DW-1:0] data);
    txn_t e;
    e.port = port; e.rd = rd; e.addr = addr;
    e.sel  = rd ? '0 : sel;
    e.data = rd ? '0 : data;
    exp_q.push_back(e);
  endtask

  // Scenarios
  task automatic test_reset();
    rst_i = 1'b1;
    clear_inputs();
    #1;
    checks++;
    if (all_out !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h, required 0", all_out);
    end
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      checks++;
      if (all_out !== '0) begin
        errors++;
        $display("FAIL idle_outputs: cycle %0d got %h, required 0", i, all_out);
      end
    end
  endtask

  task automatic test_p0_read();
    rdata_next = 32'hDEAD_BEEF;
    push_exp(0, 1, 32'h0000_1000, 4'hF, 32'hAAAA_5555);
    run_req(0, 1, 0, 32'h0000_1000, 4'hF, 32'hAAAA_5555);
    @(negedge clk_i);
  endtask

  task automatic test_p1_write();
    bit seen = 0;
    push_exp(1, 0, 32'h0000_2004, 4'b0011, 32'h1234_5678);
    p1_addr_i = 32'h0000_2004; p1_sel_i = 4'b0011; p1_data_i = 32'h1234_5678; p1_start_wr_i = 1;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk_i);
      if (busy_o) begin
        p1_addr_i = 32'hFFFF_0000;
        p1_data_i = 32'h0F0F_0F0F;
        checks++;
        if (grant_o !== 2'b10 || m_addr_o !== 32'h0000_2004 || m_data_o !== 32'h1234_5678) begin
          errors++;
          $display("FAIL p1_write_hold: got grant=%b addr=%h data=%h, required 10/00002004/12345678",
                   grant_o, m_addr_o, m_data_o);
        end
      end
      if (p1_done_o === 1'b1) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL p1_write_timeout: p1_done not seen, required done");
    end
    p1_start_wr_i = 0;
    @(negedge clk_i);
  endtask

  task automatic test_rd_wr_both();
    push_exp(0, 1, 32'h0000_6000, 4'hC, 32'hCAFE_0001);
    run_req(0, 1, 1, 32'h0000_6000, 4'hC, 32'hCAFE_0001);
    @(negedge clk_i);
  endtask

  task automatic test_alternate();
    do_reset();
    push_exp(0, 1, 32'h0000_A000, 4'hF, 32'h1);
    push_exp(1, 1, 32'h0000_B000, 4'hF, 32'h2);
    push_exp(0, 1, 32'h0000_A004, 4'hF, 32'h3);
    push_exp(1, 1, 32'h0000_B004, 4'hF, 32'h4);
    fork
      begin
        run_req(0, 1, 0, 32'h0000_A000, 4'hF, 32'h1);
        @(negedge clk_i);
        run_req(0, 1, 0, 32'h0000_A004, 4'hF, 32'h3);
      end
      begin
        run_req(1, 1, 0, 32'h0000_B000, 4'hF, 32'h2);
        @(negedge clk_i);
        run_req(1, 1, 0, 32'h0000_B004, 4'hF, 32'h4);
      end
    join
    @(negedge clk_i);
  endtask

  task automatic test_random();
    for (int n = 0; n < 8; n++) begin
      bit            port = 1'($urandom_range(0, 1));
      int            kind = $urandom_range(0, 2);
      logic [AW-1:0] addr = $urandom;
      logic [SW-1:0] sel  = SW'($urandom_range(1, 15));
      logic [DW-1:0] data = $urandom;
      push_exp(port, kind != 1, addr, sel, data);
      run_req(port, kind != 1, kind != 0, addr, sel, data);
    end
    @(negedge clk_i);
  endtask

  task automatic test_reset_mid();
    bit got_busy = 0;
    master_auto = 1'b0;
    push_exp(1, 1, 32'h0000_3000, 4'h0, 32'h0);
    p1_addr_i = 32'h0000_3000; p1_start_rd_i = 1;
    for (int i = 0; i < 20 && !got_busy; i++) begin
      @(negedge clk_i);
      got_busy = busy_o;
    end
    checks++;
    if (!got_busy) begin
      errors++;
      $display("FAIL mid_busy: busy_o never rose, required 1");
    end
    repeat (2) @(negedge clk_i);
    #2 rst_i = 1'b1;
    #1;
    checks++;
    if (all_out !== '0) begin
      errors++;
      $display("FAIL mid_async_reset: got %h, required 0", all_out);
    end
    p1_start_rd_i = 0;
    @(negedge clk_i);
    rst_i = 1'b0;
    stray_done = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      checks++;
      if (p0_done_o !== 1'b0 || p1_done_o !== 1'b0 || busy_o !== 1'b0) begin
        errors++;
        $display("FAIL mid_no_done: got p0=%0b p1=%0b busy=%0b, required 0", p0_done_o, p1_done_o, busy_o);
      end
    end
    master_auto = 1'b1;
    push_exp(0, 1, 32'h0000_4000, 4'h0, 32'h0);
    push_exp(1, 1, 32'h0000_5000, 4'h0, 32'h0);
    fork
      run_req(0, 1, 0, 32'h0000_4000, 4'hF, 32'h0);
      run_req(1, 1, 0, 32'h0000_5000, 4'hF, 32'h0);
    join
    repeat (2) @(negedge clk_i);
  endtask

  initial begin
    test_reset();
    test_p0_read();
    test_p1_write();
    test_rd_wr_both();
    test_alternate();
    test_random();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0 || done_q.size() != 0) begin
      errors++;
      $display("FAIL leftover: got %0d starts and %0d dones pending, required 0", exp_q.size(), done_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Two-port round-robin arbiter that shares the single Wishbone master between two CPU-side requesters: port 0 is instruction fetch and port 1 is load/store.
- Accepts level-held read/write requests on each port and issues exactly one single-cycle start pulse per granted transaction to the master.
- Waits for the master's done pulse, then routes done and read data back to the granted port only.
- Sits between the core's fetch/LSU logic and the WB master; one transaction is outstanding at a time.

Parameters:
- ADDR_WIDTH, 32, address width of requests and master address.
- DATA_WIDTH, 32, data width; select width is DATA_WIDTH/8.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- p0_start_rd_i  in  1  port 0 read request, level, held until p0_done_o.
- p0_start_wr_i  in  1  port 0 write request, level, held until p0_done_o.
- p0_sel_i  in  DATA_WIDTH/8  port 0 byte select.
- p0_data_i  in  DATA_WIDTH  port 0 write data.
- p0_addr_i  in  ADDR_WIDTH  port 0 address.
- p0_done_o  out  1  port 0 completion, one-cycle pulse.
- p0_data_o  out  DATA_WIDTH  port 0 read data, valid with p0_done_o.
- p1_start_rd_i, p1_start_wr_i, p1_sel_i, p1_data_i, p1_addr_i, p1_done_o, p1_data_o: same as port 0, for port 1.
- m_start_rd_o  out  1  read start pulse to the master.
- m_start_wr_o  out  1  write start pulse to the master.
- m_sel_o  out  DATA_WIDTH/8  latched byte select.
- m_data_o  out  DATA_WIDTH  latched write data.
- m_addr_o  out  ADDR_WIDTH  latched address.
- m_done_i  in  1  master completion pulse.
- m_data_i  in  DATA_WIDTH  master read data.
- grant_o  out  2  one-hot grant: bit0 = port 0, bit1 = port 1.
- busy_o  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- All outputs are registered.
- On reset:
  - FSM goes to IDLE and every output is 0.
  - last_q resets to 1, so port 0 wins the first tie.
- FSM states: IDLE, ISSUE, WAIT, RELEASE.
- IDLE:
  - A port requests when start_rd or start_wr is high.
  - If no port requests, stay in IDLE.
  - If one port requests, grant it.
  - If both request, grant the port != last_q, then update last_q to the winner.
  - Latch the winner's addr, sel and data into m_addr_o, m_sel_o and m_data_o.
  - For a read, force m_sel_o and m_data_o to 0.
  - If a port asserts rd and wr together, the read wins.
  - Go to ISSUE. m_start_rd_o or m_start_wr_o is high for exactly the ISSUE cycle.
- ISSUE: unconditionally go to WAIT; the start pulse drops.
- WAIT:
  - Hold m_addr_o, m_sel_o and m_data_o stable.
  - On m_done_i=1, assert the granted pN_done_o for one cycle, then go to RELEASE.
  - For a read, pN_data_o = m_data_i. For a write, pN_data_o = 0.
  - The ungranted port's done and data outputs stay 0.
- RELEASE: one-cycle gap so the requester can drop its level request; then go to IDLE.
- Requester rule: the requester must deassert start by the clock edge ending its done cycle. A request still held in IDLE is treated as a new transaction.
- grant_o:
  - Set on the transition out of IDLE and held through ISSUE, WAIT and RELEASE.
  - 0 in IDLE.
  - Only one bit is ever high.
- busy_o = (state != IDLE).
- m_done_i is ignored in IDLE, ISSUE and RELEASE.
- Request inputs are ignored outside IDLE. Changes to the granted port's addr/data mid-transaction have no effect.
- Minimum latency:
  - Request sampled at edge E0; start pulse in cycle E0..E1.
  - pN_done_o appears one cycle after m_done_i.
  - Back-to-back transactions are separated by at least 3 cycles (ISSUE, RELEASE, IDLE).
- Reset mid-operation: the in-flight transaction is abandoned and no done is issued. The master shares rst_i and resets with it.
- Starvation-free: with both ports continuously requesting, grants strictly alternate.

Test Plan:
- Reset, no requests → all outputs 0, busy_o=0, grant_o=00 indefinitely.
- p0 read at addr 0x0000_1000; master returns done with m_data_i=0xDEAD_BEEF.
  - m_start_rd_o pulses for one cycle with m_addr_o=0x1000 and m_sel_o=0.
  - p0_done_o pulses one cycle after m_done_i with p0_data_o=0xDEADBEEF.
  - p1_done_o stays 0.
- p1 write, addr 0x2004, data 0x1234_5678, sel 4'b0011.
  - One m_start_wr_o pulse with matching m_addr_o, m_data_o and m_sel_o.
  - p1_done_o pulses with p1_data_o=0.
  - grant_o=10 throughout.
- Both ports request continuously, reads, from reset → grant order p0, p1, p0, p1. Each done goes only to its granted port, and exactly one start pulse is issued per grant.
- p0 asserts rd and wr together → only m_start_rd_o pulses.
- Assert rst_i during WAIT, then pulse m_done_i after release.
  - Outputs go to 0 asynchronously.
  - No pN_done_o is issued.
  - The next request is arbitrated with port 0 winning the tie.
